// File: rtl/midi_tx_if.sv
// Event/strobe bundle between a MIDI event source and the midi_tx serialiser.
// The serial output travels with the bundle so a single port carries the whole link.
interface midi_tx_if;
  logic [3:0] channel;
  logic       note_on;
  logic       note_off;
  logic       cc_valid;
  logic [6:0] note_num;
  logic [6:0] note_vel;
  logic [6:0] cc_num;
  logic [6:0] cc_val;
  logic       ready;
  logic       midi_do;
  logic       msg_done;
  logic       overrun;

  modport master (
    output channel, note_on, note_off, cc_valid, note_num, note_vel, cc_num, cc_val,
    input  ready, midi_do, msg_done, overrun
  );

  modport slave (
    input  channel, note_on, note_off, cc_valid, note_num, note_vel, cc_num, cc_val,
    output ready, midi_do, msg_done, overrun
  );
endinterface

// File: rtl/midi_tx.sv
// MIDI transmitter: encodes note/CC strobes into 2- or 3-byte channel messages
// (optional running status) and sends them as back-to-back 8N1 UART frames.
module midi_tx #(
  parameter int CLKS_PER_BIT   = 3200,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  midi_tx_if.slave   bus
);

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    bytes_left_q, bytes_left_d;
  logic [23:0]   frame_q, frame_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    last_status_q, last_status_d;
  logic          do_q, do_d;
  logic          ready_q, ready_d;
  logic          msg_done_q, msg_done_d;
  logic          overrun_q, overrun_d;

  logic          idle;
  logic          any_strobe;
  logic          multi_strobe;
  logic          bit_end;
  logic [7:0]    status;
  logic [6:0]    val_a;
  logic [6:0]    val_b;

  assign idle         = (state_q == IDLE);
  assign bit_end      = (cnt_q == CNT_MAX);
  assign any_strobe   = bus.note_on | bus.note_off | bus.cc_valid;
  assign multi_strobe = (bus.note_on & bus.note_off) | (bus.note_on & bus.cc_valid) |
                        (bus.note_off & bus.cc_valid);

  // Winning event: note_off beats note_on beats cc_valid.
  always_comb begin
    status = {1'b1, 3'b011, bus.channel};
    val_a  = bus.cc_num;
    val_b  = bus.cc_val;
    if (bus.note_off) begin
      status = {1'b1, 3'b000, bus.channel};
      val_a  = bus.note_num;
      val_b  = bus.note_vel;
    end else if (bus.note_on) begin
      status = {1'b1, 3'b001, bus.channel};
      val_a  = bus.note_num;
      val_b  = bus.note_vel;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    bytes_left_d  = bytes_left_q;
    frame_d       = frame_q;
    shift_d       = shift_q;
    last_status_d = last_status_q;
    do_d          = do_q;
    ready_d       = ready_q;
    msg_done_d    = 1'b0;
    overrun_d     = idle ? multi_strobe : any_strobe;

    case (state_q)
      IDLE: begin
        if (any_strobe) begin
          // frame_q[7:0] is always the byte currently on the wire.
          if (RUNNING_STATUS && (status == last_status_q)) begin
            frame_d      = {8'h00, 1'b0, val_b, 1'b0, val_a};
            bytes_left_d = 2'd1;
          end else begin
            frame_d      = {1'b0, val_b, 1'b0, val_a, status};
            bytes_left_d = 2'd2;
          end
          last_status_d = status;
          state_d       = START;
          cnt_d         = '0;
          do_d          = 1'b0;
          ready_d       = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          do_d      = frame_q[0];
          shift_d   = {1'b0, frame_q[7:1]};
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            do_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            do_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bytes_left_q == 2'd0) begin
            state_d    = IDLE;
            ready_d    = 1'b1;
            msg_done_d = 1'b1;
          end else begin
            bytes_left_d = bytes_left_q - 2'd1;
            frame_d      = {8'h00, frame_q[23:8]};
            do_d         = 1'b0;
            state_d      = START;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        do_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      bytes_left_q  <= 2'd0;
      frame_q       <= 24'h000000;
      shift_q       <= 8'h00;
      last_status_q <= 8'h00;
      do_q          <= 1'b1;
      ready_q       <= 1'b1;
      msg_done_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      bytes_left_q  <= bytes_left_d;
      frame_q       <= frame_d;
      shift_q       <= shift_d;
      last_status_q <= last_status_d;
      do_q          <= do_d;
      ready_q       <= ready_d;
      msg_done_q    <= msg_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.midi_do  = do_q;
  assign bus.ready    = ready_q;
  assign bus.msg_done = msg_done_q;
  assign bus.overrun  = overrun_q;

endmodule
